proc_ctrl_unit: RTL and testbench

//  Control FSM for the 9-bit lab processor. Owns the instruction register (IR) and drives the bus-source selects.

---
 rtl/proc_ctrl_unit_pkg.sv | 37 +++
 rtl/proc_ctrl_unit_if.sv | 36 +++
 rtl/proc_dec3to8.sv | 20 ++
 rtl/proc_ctrl_unit.sv | 141 ++++++++++++++
 tb/tb_proc_ctrl_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/proc_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg -- shared types and constants for the 9-bit lab processor control
// unit.
//   state_t   : instruction time steps T0..T3
//   opcode_t  : ir[8:6] opcode encodings
//   GOUT_*    : encodings of the G / GF bus-drive select
//   ALU_*     : ALU operation codes
//   NREG      : number of general registers (fixed by the 3-bit X/Y fields)
// ---------------------------------------------------------------------------
package proc_pkg;

   localparam int NREG = 8;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      MV  = 3'd0,
      MVI = 3'd1,
      ADD = 3'd2,
      SUB = 3'd3,
      AND = 3'd4
   } opcode_t;

   localparam logic [1:0] GOUT_NONE = 2'b00;
   localparam logic [1:0] GOUT_G    = 2'b10;
   localparam logic [1:0] GOUT_GF   = 2'b01;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;

endpackage

// File: rtl/proc_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// proc_ctrl_unit_if -- control-unit <-> datapath signal bundle.
//   run, din             : start request and instruction / immediate word
//   rout, gout, dinout   : bus source selects (rout is one-hot [0:7])
//   rin, ain, gin        : register load enables (rin is one-hot [0:7])
//   alu_op               : ALU operation
//   ir, done             : current instruction, last-step flag
// Modports:
//   master : the control unit (drives selects/enables, reads run/din)
//   slave  : the datapath side (drives run/din, reads selects/enables)
// ---------------------------------------------------------------------------
interface proc_ctrl_unit_if #(
   parameter int DW = 9
);
   logic          run;
   logic [DW-1:0] din;
   logic [0:7]    rout;
   logic [1:0]    gout;
   logic          dinout;
   logic [0:7]    rin;
   logic          ain;
   logic          gin;
   logic [1:0]    alu_op;
   logic [DW-1:0] ir;
   logic          done;

   modport master (
      input  run, din,
      output rout, gout, dinout, rin, ain, gin, alu_op, ir, done
   );

   modport slave (
      output run, din,
      input  rout, gout, dinout, rin, ain, gin, alu_op, ir, done
   );
endinterface

// File: rtl/proc_dec3to8.sv
// ---------------------------------------------------------------------------
// proc_dec3to8 -- 3-bit register field to one-hot register select.
//   sel    in  3        register number
//   onehot out [0:7]    onehot[i] = (sel == i)
// ---------------------------------------------------------------------------
module proc_dec3to8
   import proc_pkg::*;
(
   input  logic [2:0]       sel,
   output logic [0:NREG-1]  onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_bit
         assign onehot[gi] = (sel == 3'(gi));
      end
   endgenerate

endmodule

// File: rtl/proc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// proc_ctrl_unit -- control FSM for the 9-bit lab processor.
// Owns the instruction register and sequences each instruction over time
// steps T0..T3, decoding (state, ir) into bus-source selects, register load
// enables and the ALU op. done is high during the final step.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    proc_ctrl_unit_if.master (run, din in; rout, gout, dinout, rin,
//          ain, gin, alu_op, ir, done out)
// Configuration:
//   PROC_CTRL_GF_EN defined   : opcode 100 executes "and" via the GF path.
//   PROC_CTRL_GF_EN undefined : opcode 100 is a NOP.
// ---------------------------------------------------------------------------
module proc_ctrl_unit
   import proc_pkg::*;
#(
   parameter int DW = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   proc_ctrl_unit_if.master   bus
);

   // State codes mirror the package enum so both stay in lockstep.
   localparam logic [1:0] S_T0 = T0;
   localparam logic [1:0] S_T1 = T1;
   localparam logic [1:0] S_T2 = T2;
   localparam logic [1:0] S_T3 = T3;

   logic [1:0]    state_reg, state_next;
   logic [DW-1:0] ir_reg;
   opcode_t       op;
   logic [0:7]    x_oh, y_oh;

   // Decoded intent, turned into bus selects below.
   logic       sel_x, sel_y, rin_en;
   logic       dinout, ain, gin, done;
   logic [1:0] gout, alu_op;

   assign op = opcode_t'(ir_reg[8:6]);

   proc_dec3to8 u_dec_x (.sel(ir_reg[5:3]), .onehot(x_oh));
   proc_dec3to8 u_dec_y (.sel(ir_reg[2:0]), .onehot(y_oh));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_T0;
         ir_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_T0 && bus.run)
            ir_reg <= bus.din;
      end
   end

   always_comb begin
      state_next = state_reg;
      sel_x      = 1'b0;
      sel_y      = 1'b0;
      rin_en     = 1'b0;
      dinout     = 1'b0;
      ain        = 1'b0;
      gin        = 1'b0;
      gout       = GOUT_NONE;
      alu_op     = ALU_ADD;
      done       = 1'b0;
      case (state_reg)
         S_T0: begin
            if (bus.run)
               state_next = S_T1;
         end
         S_T1: begin
            case (op)
               MV: begin
                  sel_y      = 1'b1;
                  rin_en     = 1'b1;
                  done       = 1'b1;
                  state_next = S_T0;
               end
               MVI: begin
                  dinout     = 1'b1;
                  rin_en     = 1'b1;
                  done       = 1'b1;
                  state_next = S_T0;
               end
               ADD, SUB
`ifdef PROC_CTRL_GF_EN
               , AND
`endif
               : begin
                  sel_x      = 1'b1;
                  ain        = 1'b1;
                  state_next = S_T2;
               end
               default: begin
                  // Unused opcodes retire as a single-step NOP.
                  done       = 1'b1;
                  state_next = S_T0;
               end
            endcase
         end
         S_T2: begin
            sel_y = 1'b1;
            gin   = 1'b1;
            if (op == SUB)
               alu_op = ALU_SUB;
`ifdef PROC_CTRL_GF_EN
            else if (op == AND)
               alu_op = ALU_AND;
`endif
            state_next = S_T3;
         end
         S_T3: begin
            gout = GOUT_G;
`ifdef PROC_CTRL_GF_EN
            // "and" results live in GF rather than G.
            if (op == AND)
               gout = GOUT_GF;
`endif
            rin_en     = 1'b1;
            done       = 1'b1;
            state_next = S_T0;
         end
         default: state_next = S_T0;
      endcase
   end

   // Only one of sel_x / sel_y / dinout / gout is ever asserted in a step,
   // so the bus mux never has to arbitrate.
   assign bus.rout   = sel_x ? x_oh : (sel_y ? y_oh : '0);
   assign bus.rin    = rin_en ? x_oh : '0;
   assign bus.gout   = gout;
   assign bus.dinout = dinout;
   assign bus.ain    = ain;
   assign bus.gin    = gin;
   assign bus.alu_op = alu_op;
   assign bus.done   = done;
   assign bus.ir     = ir_reg;

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_proc_ctrl_unit -- directed bench for proc_ctrl_unit.
// Outputs are packed as {rout, gout, dinout, rin, ain, gin, alu_op, done}
// and compared with hand-computed vectors. A background check enforces the
// single-bus-source and single-rin invariants every cycle out of reset.
// ---------------------------------------------------------------------------
module tb_proc_ctrl_unit;

   logic clk;
   logic rst_n;
   int   n_asserts;
   int   n_fails;

   proc_ctrl_unit_if #(.DW(9)) bus ();

   proc_ctrl_unit #(.DW(9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] ev(input logic [0:7] r, input logic [1:0] g,
                                      input logic di, input logic [0:7] ri,
                                      input logic a, input logic gi,
                                      input logic [1:0] op, input logic d);
      return {r, g, di, ri, a, gi, op, d};
   endfunction

   function automatic logic [23:0] actual();
      return {bus.rout, bus.gout, bus.dinout, bus.rin, bus.ain, bus.gin,
              bus.alu_op, bus.done};
   endfunction

   task automatic check_out(input string tag, input logic [23:0] exp_v);
      logic [23:0] obs;
      obs = actual();
      n_asserts++;
      assert (obs === exp_v) else begin
         n_fails++;
         $error("FAIL %s outputs observed=%06h expected=%06h", tag, obs, exp_v);
      end
   endtask

   task automatic check_ir(input string tag, input logic [8:0] exp_v);
      n_asserts++;
      assert (bus.ir === exp_v) else begin
         n_fails++;
         $error("FAIL %s ir observed=%b expected=%b", tag, bus.ir, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Invariants: at most one bus source, at most one register load.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         n_asserts++;
         assert ($countones({bus.rout, bus.gout, bus.dinout}) <= 1 &&
                 $countones(bus.rin) <= 1) else begin
            n_fails++;
            $error("FAIL onehot_invariant rout=%b gout=%b dinout=%b rin=%b",
                   bus.rout, bus.gout, bus.dinout, bus.rin);
         end
      end
   end

   localparam logic [23:0] IDLE = 24'h0;

   initial begin
      n_asserts = 0;
      n_fails   = 0;
      rst_n     = 1'b0;
      bus.run   = 1'b0;
      bus.din   = '0;

      // Power-on reset
      tick(); tick();
      check_out("reset_outputs", IDLE);
      check_ir("reset_ir", 9'b0);
      rst_n = 1'b1;
      tick();
      check_out("idle_after_reset", IDLE);

      // mvi R2,#5
      $display("txn mvi R2,#5");
      bus.run = 1'b1; bus.din = 9'b001_010_000;
      tick();
      bus.run = 1'b0; bus.din = 9'd5;
      check_ir("mvi_ir", 9'b001_010_000);
      check_out("mvi_t1", ev(8'b0, 2'b00, 1'b1, 8'b0010_0000, 1'b0, 1'b0, 2'd0, 1'b1));
      tick();
      check_out("mvi_back_t0", IDLE);

      // mv R5,R2
      $display("txn mv R5,R2");
      bus.run = 1'b1; bus.din = 9'b000_101_010;
      tick();
      bus.run = 1'b0;
      check_out("mv_t1", ev(8'b0010_0000, 2'b00, 1'b0, 8'b0000_0100, 1'b0, 1'b0, 2'd0, 1'b1));
      tick();
      check_out("mv_back_t0", IDLE);

      // sub R1,R3
      $display("txn sub R1,R3");
      bus.run = 1'b1; bus.din = 9'b011_001_011;
      tick();
      bus.run = 1'b0;
      check_out("sub_t1", ev(8'b0100_0000, 2'b00, 1'b0, 8'b0, 1'b1, 1'b0, 2'd0, 1'b0));
      tick();
      check_out("sub_t2", ev(8'b0001_0000, 2'b00, 1'b0, 8'b0, 1'b0, 1'b1, 2'd1, 1'b0));
      tick();
      check_out("sub_t3", ev(8'b0, 2'b10, 1'b0, 8'b0100_0000, 1'b0, 1'b0, 2'd0, 1'b1));
      tick();
      check_out("sub_back_t0", IDLE);

      // opcode 100, X=4, Y=6
      $display("txn op100 R4,R6");
      bus.run = 1'b1; bus.din = 9'b100_100_110;
      tick();
      bus.run = 1'b0;
`ifdef PROC_CTRL_GF_EN
      check_out("and_t1", ev(8'b0000_1000, 2'b00, 1'b0, 8'b0, 1'b1, 1'b0, 2'd0, 1'b0));
      tick();
      check_out("and_t2", ev(8'b0000_0010, 2'b00, 1'b0, 8'b0, 1'b0, 1'b1, 2'd2, 1'b0));
      tick();
      check_out("and_t3", ev(8'b0, 2'b01, 1'b0, 8'b0000_1000, 1'b0, 1'b0, 2'd0, 1'b1));
`else
      check_out("op100_nop_t1", ev(8'b0, 2'b00, 1'b0, 8'b0, 1'b0, 1'b0, 2'd0, 1'b1));
`endif
      tick();
      check_out("op100_back_t0", IDLE);

      // Back-to-back: add R0,R1 then mv R7,R0 with run held high
      $display("txn add R0,R1 then mv R7,R0 back-to-back");
      bus.run = 1'b1; bus.din = 9'b010_000_001;
      tick();
      bus.din = 9'b000_111_000;   // must be ignored until T0 comes round
      check_out("b2b_add_t1", ev(8'b1000_0000, 2'b00, 1'b0, 8'b0, 1'b1, 1'b0, 2'd0, 1'b0));
      tick();
      check_out("b2b_add_t2", ev(8'b0100_0000, 2'b00, 1'b0, 8'b0, 1'b0, 1'b1, 2'd0, 1'b0));
      tick();
      check_out("b2b_add_t3", ev(8'b0, 2'b10, 1'b0, 8'b1000_0000, 1'b0, 1'b0, 2'd0, 1'b1));
      check_ir("b2b_ir_held", 9'b010_000_001);
      tick();
      check_out("b2b_t0", IDLE);
      check_ir("b2b_ir_before_load", 9'b010_000_001);
      tick();
      bus.run = 1'b0;
      check_ir("b2b_ir_loaded", 9'b000_111_000);
      check_out("b2b_mv_t1", ev(8'b1000_0000, 2'b00, 1'b0, 8'b0000_0001, 1'b0, 1'b0, 2'd0, 1'b1));
      tick();
      check_out("b2b_back_t0", IDLE);

      // Reset mid-T2 of add R3,R3
      $display("txn add R3,R3 with reset in T2");
      bus.run = 1'b1; bus.din = 9'b010_011_011;
      tick();
      bus.run = 1'b0;
      tick();
      check_out("add_rr_t2", ev(8'b0001_0000, 2'b00, 1'b0, 8'b0, 1'b0, 1'b1, 2'd0, 1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset_outputs", IDLE);
      check_ir("async_reset_ir", 9'b0);
      tick();
      check_out("reset_held_outputs", IDLE);
      rst_n = 1'b1;
      tick();
      check_out("after_reset_idle", IDLE);
      // State must be T0: a new mvi loads and executes immediately.
      bus.run = 1'b1; bus.din = 9'b001_110_000;
      tick();
      bus.run = 1'b0;
      check_ir("after_reset_ir", 9'b001_110_000);
      check_out("after_reset_mvi_t1", ev(8'b0, 2'b00, 1'b1, 8'b0000_0010, 1'b0, 1'b0, 2'd0, 1'b1));
      tick();
      check_out("final_idle", IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
